// File: rtl/chip8_rom_loader.sv
// CHIP-8 ROM loader: streams a host image into CPU memory.
// Owns the upload port mux, optional zero-fill, guard gaps.
module chip8_rom_loader #(
  parameter logic [11:0] LOAD_BASE    = 12'h200,
  parameter logic [11:0] MEM_TOP      = 12'hFFF,
  parameter bit          CLEAR_EN     = 1'b1,
  parameter int unsigned GUARD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        start,
  input  logic        host_valid,
  input  logic [7:0]  host_data,
  input  logic        host_last,
  output logic        host_ready,
  output logic        uploading,
  output logic        upload_en,
  output logic [11:0] upload_addr,
  output logic [7:0]  upload_data,
  output logic [11:0] byte_count,
  output logic        overflow,
  output logic        done
);

  localparam logic [11:0] IMG_MAX    = MEM_TOP - LOAD_BASE + 12'd1;
  localparam logic [7:0]  GUARD_LAST = 8'(GUARD_CYCLES - 1);
  localparam logic [7:0]  GUARD_END  = 8'(GUARD_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_CLEAR,
    S_LOAD,
    S_DRAIN,
    S_POST,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  guard_q, guard_d;
  logic [11:0] ptr_q, ptr_d;
  logic        ready_q, ready_d;
  logic        up_q, up_d;
  logic        en_q, en_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [11:0] cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic        accept;

  assign accept = host_valid & ready_q;

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    ptr_d   = ptr_q;
    ready_d = ready_q;
    up_d    = up_q;
    en_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PRE;
          up_d    = 1'b1;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          guard_d = '0;
          ptr_d   = LOAD_BASE;
          addr_d  = LOAD_BASE;
        end
      end
      S_PRE: begin
        if (guard_q == GUARD_LAST) begin
          ptr_d  = LOAD_BASE;
          addr_d = LOAD_BASE;
          if (CLEAR_EN) begin
            state_d = S_CLEAR;
            en_d    = 1'b1;
            data_d  = '0;
          end else begin
            state_d = S_LOAD;
            ready_d = 1'b1;
          end
        end else begin
          guard_d = guard_q + 8'd1;
        end
      end
      S_CLEAR: begin
        if (addr_q == MEM_TOP) begin
          state_d = S_LOAD;
          ready_d = 1'b1;
          ptr_d   = LOAD_BASE;
        end else begin
          en_d   = 1'b1;
          addr_d = addr_q + 12'd1;
          data_d = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          en_d   = 1'b1;
          addr_d = ptr_q;
          data_d = host_data;
          if (cnt_q != IMG_MAX) cnt_d = cnt_q + 12'd1;
          if (ptr_q != MEM_TOP) ptr_d = ptr_q + 12'd1;
          if (host_last) begin
            state_d = S_POST;
            ready_d = 1'b0;
            guard_d = '0;
          end else if (ptr_q == MEM_TOP) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (accept) begin
          ovf_d = 1'b1;
          if (host_last) begin
            state_d = S_POST;
            ready_d = 1'b0;
            guard_d = 8'd1;
          end
        end
      end
      S_POST: begin
        if (guard_q == GUARD_END) begin
          state_d = S_DONE;
          up_d    = 1'b0;
          done_d  = 1'b1;
        end else begin
          guard_d = guard_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts a load at once.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      guard_q <= '0;
      ptr_q   <= '0;
      ready_q <= 1'b0;
      up_q    <= 1'b0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
      up_q    <= up_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign host_ready  = ready_q;
  assign uploading   = up_q;
  assign upload_en   = en_q;
  assign upload_addr = addr_q;
  assign upload_data = data_q;
  assign byte_count  = cnt_q;
  assign overflow    = ovf_q;
  assign done        = done_q;

endmodule

// File: doc/chip8_rom_loader.md
Name: chip8_rom_loader

Overview:
- Upstream feeder for the CHIP-8 core's upload port.
- Accepts a byte stream from the OSD/SPI host and owns the `uploading` select, which halts the CPU and muxes memory port A.
- Optionally zero-fills program RAM, then writes the image from LOAD_BASE upward.
- Drives `upload_en`, `upload_addr` and `upload_data`, and reports completion, byte count and overflow.

Parameters:
- LOAD_BASE, 12'h200, first address written by the image and by the clear pass.
- MEM_TOP, 12'hFFF, last writable address.
- CLEAR_EN, 1, 1 = zero-fill LOAD_BASE..MEM_TOP before loading.
- GUARD_CYCLES, 4, idle cycles with `uploading`=1 and `upload_en`=0, before the first write and after the last write (clock-mux settle time).

Ports:
- clk  in  1  loader clock; also drives `upload_clk` at the top level.
- reset_i  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a load.
- host_valid  in  1  host_data/host_last valid.
- host_data  in  8  image byte.
- host_last  in  1  marks the final byte of the image.
- host_ready  out  1  loader accepts a byte this cycle.
- uploading  out  1  memory port owned by the loader, CPU halted.
- upload_en  out  1  write strobe to CPU memory.
- upload_addr  out  12  write address.
- upload_data  out  8  write data.
- byte_count  out  12  image bytes written in the last or current load.
- overflow  out  1  image exceeded MEM_TOP-LOAD_BASE+1 bytes.
- done  out  1  one-cycle pulse at end of load.

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - All outputs 0: `upload_addr`=0, `upload_data`=0, `byte_count`=0, `overflow`=0, `host_ready`=0.
  - A reset mid-load aborts immediately: `uploading` and `upload_en` drop asynchronously, and memory contents are left partial.
- States: IDLE -> PRE -> CLEAR -> LOAD -> (DRAIN) -> POST -> DONE -> IDLE. All outputs are registered.
- IDLE:
  - `start`=1 -> PRE.
  - Same edge: `uploading`<=1, `overflow`<=0, `byte_count`<=0, guard counter<=0.
  - `start` is ignored in every other state.
- PRE:
  - `uploading`=1, `upload_en`=0.
  - After GUARD_CYCLES cycles: go to CLEAR if CLEAR_EN, else LOAD.
  - `upload_addr` is preset to LOAD_BASE.
- CLEAR:
  - Each cycle: `upload_en`=1, `upload_data`=0, `upload_addr` steps from LOAD_BASE through MEM_TOP.
  - Takes exactly MEM_TOP-LOAD_BASE+1 cycles (3584 at defaults).
  - `host_ready`=0 throughout.
  - After the MEM_TOP write -> LOAD, with the address pointer = LOAD_BASE.
- LOAD:
  - `host_ready`=1.
  - Accept on `host_valid`&`host_ready`. The next cycle presents `upload_en`=1, `upload_data`=byte, `upload_addr`=pointer. Pointer and `byte_count` each increment by 1 (1-cycle write latency).
  - `upload_en`=0 in cycles with no accept.
  - Accepted byte with `host_last`=1 -> POST after its write.
  - Accepted byte written at MEM_TOP with `host_last`=0 -> DRAIN. The pointer does not wrap.
- DRAIN:
  - `host_ready`=1; `upload_en`=0; bytes are discarded.
  - First discarded byte sets `overflow`=1.
  - Accept with `host_last` -> POST.
  - `byte_count` stays at MEM_TOP-LOAD_BASE+1.
- POST: `uploading`=1, `upload_en`=0 for GUARD_CYCLES cycles -> DONE.
- DONE: `uploading`<=0, `done`=1 for exactly one cycle -> IDLE.
- Persistence: `byte_count` and `overflow` hold until the next `start`. `upload_addr` and `upload_data` hold their last values when idle.
- Arithmetic: the 12-bit pointer never exceeds MEM_TOP; `byte_count` saturates at MEM_TOP-LOAD_BASE+1.
- Host protocol: `host_last` with `host_valid`=0 is ignored. An image is at least 1 byte.

Test Plan:
- Reset held, then released with no start -> all outputs 0 for 100 cycles.
- CLEAR_EN=1, start, 4-byte image A2 1E 60 05 (last on 05) -> clear covers 3584 writes of 0 over 200..FFF. Then writes 200=A2, 201=1E, 202=60, 203=05. `byte_count`=4, `overflow`=0, `done` is a single pulse, and `uploading` deasserts 4 cycles after the last write.
- CLEAR_EN=0, host_valid toggling every other cycle, 3 bytes -> exactly 3 `upload_en` pulses at 200, 201, 202, each one cycle after its accept. No writes occur in gap cycles.
- CLEAR_EN=0, 3586-byte stream -> last write at FFF. Bytes 3585 and 3586 are discarded, `overflow`=1, `byte_count`=3584 (E00), `done` pulses.
- `start` pulsed during LOAD -> no effect: pointer continues and only one `done` pulse occurs.
- reset_i asserted mid-CLEAR at address 0x400 -> `uploading`=0 and `upload_en`=0 with no clock edge. After release, a new `start` restarts the clear from 200.
